// File: rtl/bus_arbiter_rr4.sv
// Round-robin bus arbiter: registered one-hot grant, per-tenure hold limit,
// and a single turnaround cycle between consecutive tenures.
module bus_arbiter_rr4 #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout
);

    localparam int PW = IDW + 1;
    localparam logic [7:0] CMAX = 8'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           timeout_q, timeout_d;

    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] next_ptr;
    logic [PW-1:0]  idx;

    // Walk backwards so the requester closest to ptr overwrites the rest.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + PW'(i);
            if (idx >= PW'(N)) begin
                idx = idx - PW'(N);
            end
            if (req[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    assign next_ptr = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            GRANT: begin
                if (!req[owner_q] || cnt_q == CMAX) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    owner_d   = '0;
                    cnt_d     = '0;
                    ptr_d     = next_ptr;
                    // a release at the limit edge is not a timeout
                    timeout_d = req[owner_q];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (found) begin
                    state_d       = GRANT;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    cnt_d         = 8'd1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    owner_d = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = owner_q;
    assign busy     = |grant_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Bench for bus_arbiter_rr4: tenure-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bus_arbiter_rr4;

    localparam int N     = 4;
    localparam int MH    = 4;
    localparam int IDW   = 2;
    localparam int BOUND = (N - 1) * (MH + 1) + 1 + MH;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;

    int n_chk  = 0;
    int n_fail = 0;

    bus_arbiter_rr4 #(.N(N), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // owner < 0 means nobody holds the bus
    typedef struct {
        int owner;
        int held;
        int ptr;
        bit gap;
        bit to;
    } mdl_t;

    localparam mdl_t MRST = '{owner: -1, held: 0, ptr: 0, gap: 1'b0, to: 1'b0};

    mdl_t m;

    function automatic mdl_t step(mdl_t s, logic [N-1:0] r);
        mdl_t n;
        n    = s;
        n.to = 1'b0;
        if (s.owner >= 0) begin
            if (!r[s.owner] || s.held == MH) begin
                n.to    = r[s.owner];
                n.owner = -1;
                n.held  = 0;
                n.gap   = 1'b1;
                n.ptr   = (s.owner + 1) % N;
            end else begin
                n.held = s.held + 1;
            end
        end else begin
            n.gap = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (n.owner < 0 && r[(s.ptr + k) % N]) begin
                    n.owner = (s.ptr + k) % N;
                    n.held  = 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= MRST;
        else      m <= step(m, req);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    int wcnt [N];

    always @(negedge clk) begin
        logic [N-1:0] eg;
        eg = (m.owner >= 0) ? N'(1 << m.owner) : '0;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_gid", 32'(grant_id), (m.owner >= 0) ? 32'(m.owner) : 32'd0);
        chk("model_busy", 32'(busy), 32'(m.owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m.to));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        if (m.gap) chk("gap_nogrant", 32'(grant), 32'd0);
        if (grant != '0) chk("gid_match", 32'(grant), 32'(N'(1) << grant_id));
        else             chk("gid_zero", 32'(grant_id), 32'd0);
        chk("busy_match", 32'(busy), 32'(grant != '0));
        for (int i = 0; i < N; i++) begin
            if (rst && req[i] && !grant[i]) wcnt[i] <= wcnt[i] + 1;
            else                            wcnt[i] <= 0;
            if (rst && req[i]) chk("starve", 32'(wcnt[i] <= BOUND), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [N-1:0] eg;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        rst = 1'b0;
        req = '0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_grant", 32'(grant), 32'd0);

        // all requesting: full rotation, every tenure expires
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            eg = 4'b0001 << (t % 4);
            for (int c = 0; c < MH; c++) begin
                tick();
                chk("rot_grant", 32'(grant), 32'(eg));
            end
            if (t == 4) req = '0;
            tick();
            chk("rot_gap", 32'(grant), 32'd0);
            chk("rot_timeout", 32'(timeout), (t == 4) ? 32'd0 : 32'd1);
        end
        tick();
        chk("rot_ptr", 32'(m.ptr), 32'd1);

        // single requester, voluntary release after 3 cycles
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("single_grant", 32'(grant), 32'h4);
            chk("single_to", 32'(timeout), 32'd0);
        end
        req = '0;
        tick();
        chk("single_gap", 32'(grant), 32'd0);
        chk("single_gap_to", 32'(timeout), 32'd0);
        tick();
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_ptr", 32'(m.ptr), 32'd3);

        // fairness across the wrap
        req = 4'b1001;
        tick();
        chk("wrap_first", 32'(grant), 32'h8);
        chk("wrap_gid", 32'(grant_id), 32'd3);
        repeat (MH - 1) tick();
        tick();
        chk("wrap_gap", 32'(grant), 32'd0);
        chk("wrap_to", 32'(timeout), 32'd1);
        tick();
        chk("wrap_second", 32'(grant), 32'h1);
        req = '0;
        tick();
        tick();
        chk("wrap_ptr", 32'(m.ptr), 32'd1);

        // asynchronous reset mid-tenure
        req = 4'b0110;
        tick();
        chk("ar_pre", 32'(grant), 32'h2);
        tick();
        #1 rst = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_gid", 32'(grant_id), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("ar_after", 32'(grant), 32'h2);
        req = '0;
        tick();
        tick();

        // soak: held request patterns, checked by the model every cycle
        for (int k = 0; k < 60; k++) begin
            req = N'($urandom_range(0, (1 << N) - 1));
            repeat ($urandom_range(1, 8)) tick();
        end
        req = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr4.md
BUS_ARBITER_RR4 -- requirements
Module: bus_arbiter_rr4

Interface
REQ-001 Parameter N, 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, 8, maximum consecutive grant cycles per tenure (2..255).
REQ-003 Parameter IDW, $clog2(N), width of grant_id.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N  per-requester bus request, level; requester holds it high for its whole transaction.
REQ-007 grant  output  N  one-hot bus grant, registered.
REQ-008 grant_id  output  IDW  index of current owner, registered; 0 when no grant.
REQ-009 busy  output  1  high while any grant bit is high.
REQ-010 timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD expiry.

Function
REQ-011 FSM states SHALL be IDLE, GRANT, GAP; encoding is free.
REQ-012 Rotation pointer ptr (IDW bits) SHALL name the highest-priority requester; search order ptr, ptr+1, ..., wrapping mod N.
REQ-013 IDLE or GAP with req!=0 sampled at edge k: SHALL enter GRANT at edge k; grant bit of the first set req in search order high from edge k; latency one cycle.
REQ-014 IDLE with req==0: SHALL stay IDLE; GAP with req==0: SHALL go to IDLE.
REQ-015 In GRANT, hold counter SHALL be 1 in the first grant cycle and increment each cycle of the tenure.
REQ-016 GRANT, owner w: if req[w]==0 at an edge, SHALL go to GAP with grant=0 after that edge; no timeout pulse.
REQ-017 GRANT: if req[w]==1 and counter==MAX_HOLD at an edge, SHALL go to GAP with grant=0; timeout high for exactly that GAP cycle.
REQ-018 Both tenure-end conditions at the same edge: release (REQ-016) SHALL take precedence; timeout stays low.
REQ-019 On every GRANT-to-GAP transition ptr SHALL become (w+1) mod N; ptr SHALL not change otherwise.
REQ-020 GAP SHALL last exactly one cycle (bus turnaround); grant SHALL be all-zero in GAP and IDLE.
REQ-021 Requests from non-owners during GRANT SHALL be ignored; no preemption.
REQ-022 A timed-out requester still asserting req SHALL be eligible again; it wins only if no other requester is set ahead of it in search order.
REQ-023 Requester with req high continuously SHALL be granted within (N-1)*(MAX_HOLD+1)+1 cycles of a GAP or IDLE cycle.
REQ-024 grant SHALL be one-hot or zero in every cycle; grant_id, busy SHALL be consistent with grant in the same cycle.
REQ-025 ptr wrap from N-1 SHALL go to 0; for non-power-of-2 N, ptr values >= N SHALL never occur.

Reset
REQ-026 rst low SHALL asynchronously force: state IDLE, grant=0, grant_id=0, busy=0, timeout=0, ptr=0, counter=0.
REQ-027 rst asserted mid-tenure SHALL drop grant immediately, without waiting for a clock edge.
REQ-028 First edge after rst deasserts SHALL evaluate req as in IDLE; requester 0 has top priority.

Verification
REQ-029 Single requester: req=4'b0100 held 3 cycles then 0 -> grant=4'b0100 for 3 cycles starting one cycle after req; then GAP; then IDLE; ptr=3; timeout never high.
REQ-030 All req=4'b1111 held, MAX_HOLD=4 -> grant sequence 0001,0010,0100,1000,0001; each 4 cycles with one GAP cycle between; timeout pulse in every GAP.
REQ-031 Fairness after wrap: ptr=3, req=4'b1001 -> grant=4'b1000 first, then 4'b0001.
REQ-032 Release and expiry at the same edge: req[w] drops at the edge where counter==MAX_HOLD -> GAP, timeout=0.
REQ-033 rst pulsed low mid-tenure between clock edges: grant=0 asynchronously; after release with req=4'b0110, grant=4'b0010.
REQ-034 Every run: assertion checks one-hot grant, no grant in GAP, grant_id/busy consistency, and the REQ-023 starvation bound.
